seven_segment_capture: RTL
==========================

SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

Interface
REQ-001 Parameter: STABLE_CYCLES, default 1024, number of consecutive identical samples required before a digit is accepted.
REQ-002 Port: clock_100Mhz  input  1  single system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: anode_in  input  4  multiplexed anode pattern, active-low; bit 3 = thousands digit, bit 0 = ones digit.
REQ-005 Port: segment_in  input  7  cathode pattern, active-low, order {a,b,c,d,e,f,g}.
REQ-006 Port: captured_number  output  16  binary value 0..9999 of the last complete frame.
REQ-007 Port: number_valid  output  1  one-cycle pulse when captured_number updates.
REQ-008 Port: pattern_error  output  1  one-cycle pulse on an illegal stable pattern; present only with SEG_CAPTURE_ERR_EN.

Function
REQ-009 Valid anode SHALL be exactly one low bit: 0111=d3, 1011=d2, 1101=d1, 1110=d0; 1111 (blank) SHALL be ignored silently.
REQ-010 Decode SHALL map 0000001..0000100 to 0..9: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9; any other pattern is illegal.
REQ-011 Stability counter SHALL clear on any change of {anode_in, segment_in} and saturate at STABLE_CYCLES.
REQ-012 Capture event SHALL occur in exactly one cycle per dwell: the cycle the counter reaches STABLE_CYCLES-1 with a valid anode.
REQ-013 Capture SHALL store the digit in its slot and set its bit in a 4-bit seen mask; recapture of a seen slot overwrites it.
REQ-014 Capture order SHALL be irrelevant; a frame completes when the mask is 1111.
REQ-015 FSM states: COLLECT, CONVERT; COLLECT->CONVERT the cycle after the mask becomes 1111; CONVERT->COLLECT unconditionally after one cycle.
REQ-016 On entry to CONVERT the mask and the stored digits SHALL be snapshotted and the mask cleared; captures during CONVERT count toward the next frame.
REQ-017 CONVERT SHALL compute d3*1000+d2*100+d1*10+d0 in 14 bits, zero-extended to 16; captured_number and number_valid register at the end of CONVERT (latency: 2 cycles after the final capture).
REQ-018 captured_number SHALL hold its value between frames.
REQ-019 Anode with two or more low bits SHALL produce no capture.

Reset
REQ-020 Reset SHALL zero captured_number, number_valid, pattern_error, the stability counter, the digit slots and the mask, and force COLLECT.
REQ-021 Reset asserted mid-frame or during CONVERT SHALL discard the partial frame; no number_valid follows.

Configuration
REQ-022 Macro SEG_CAPTURE_ERR_EN defined: an illegal cathode pattern, or a multi-low anode, at the capture point SHALL pulse pattern_error for one cycle and clear the mask.
REQ-023 Macro SEG_CAPTURE_ERR_EN undefined: pattern_error port absent; an illegal cathode SHALL decode as 0 and be captured; a multi-low anode is ignored.

Structure
REQ-024 Package seg7_pkg SHALL hold the ten cathode pattern constants, the four anode select constants and the FSM state type, shared with the display driver.
REQ-025 Sub-module seg7_decode SHALL be purely combinational, mapping 7-bit cathode to 4-bit BCD plus a legal flag.

Verification
REQ-026 Drive 9789 as a d3..d0 scan with a 2000-cycle dwell per digit -> exactly one number_valid per scan, captured_number=16'd9789.
REQ-027 Scan 0042 in order d0,d2,d1,d3 -> captured_number=16'd42 after the d3 capture.
REQ-028 Inject a 500-cycle segment glitch to 7'b0000000 inside a d1 dwell of digit 5, then restore 5 -> 5 is recaptured, the frame value is unchanged, and no spurious 8 appears.
REQ-029 With ERR_EN defined, hold 7'b1111111 on anode 1101 for 2000 cycles -> one pattern_error pulse, mask cleared, no number_valid; without ERR_EN the tens digit = 0.
REQ-030 Assert reset for 1 cycle after three digits of 1234 are captured -> outputs are 0 and the next full scan of 5678 yields exactly 16'd5678.
REQ-031 Hold anode 1111 for 10000 cycles -> no capture, no pulses, captured_number unchanged.

Source files
------------

// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared seven-segment cathode/anode constants, capture FSM
//                state type and BCD-to-binary helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  // Active-low cathode patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] c_seg_0 = 7'b0000001;
  localparam logic [6:0] c_seg_1 = 7'b1001111;
  localparam logic [6:0] c_seg_2 = 7'b0010010;
  localparam logic [6:0] c_seg_3 = 7'b0000110;
  localparam logic [6:0] c_seg_4 = 7'b1001100;
  localparam logic [6:0] c_seg_5 = 7'b0100100;
  localparam logic [6:0] c_seg_6 = 7'b0100000;
  localparam logic [6:0] c_seg_7 = 7'b0001111;
  localparam logic [6:0] c_seg_8 = 7'b0000000;
  localparam logic [6:0] c_seg_9 = 7'b0000100;

  localparam logic [3:0] c_an_d3    = 4'b0111;
  localparam logic [3:0] c_an_d2    = 4'b1011;
  localparam logic [3:0] c_an_d1    = 4'b1101;
  localparam logic [3:0] c_an_d0    = 4'b1110;
  localparam logic [3:0] c_an_blank = 4'b1111;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    CONVERT = 1'b1
  } cap_state_t;

  function automatic logic [13:0] frame_value(input logic [3:0][3:0] d);
    return (14'(d[3]) * 14'd1000) + (14'(d[2]) * 14'd100)
         + (14'(d[1]) * 14'd10) + 14'(d[0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational active-low cathode to BCD decoder with legal flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] segments,
  output logic [3:0] digit,
  output logic       legal
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (segments)
      c_seg_0: digit = 4'd0;
      c_seg_1: digit = 4'd1;
      c_seg_2: digit = 4'd2;
      c_seg_3: digit = 4'd3;
      c_seg_4: digit = 4'd4;
      c_seg_5: digit = 4'd5;
      c_seg_6: digit = 4'd6;
      c_seg_7: digit = 4'd7;
      c_seg_8: digit = 4'd8;
      c_seg_9: digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seven_segment_capture.sv
// ============================================================================
//  Module      : seven_segment_capture
//  Description : Recovers a 4-digit number from a multiplexed seven-segment
//                display scan. Optional SEG_CAPTURE_ERR_EN adds pattern_error.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_segment_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024
)
(
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [3:0]  anode_in,
  input  logic [6:0]  segment_in,
  output logic [15:0] captured_number,
  output logic        number_valid
`ifdef SEG_CAPTURE_ERR_EN
  ,
  output logic        pattern_error
`endif
);

  localparam int                 c_cnt_w   = $clog2(STABLE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STABLE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_hit = c_cnt_w'(STABLE_CYCLES - 1);

  logic [10:0]        w_sample;
  logic [10:0]        r_sample;
  logic [c_cnt_w-1:0] r_count;
  logic [3:0]         w_anode;
  logic [3:0]         w_digit;
  logic               w_legal;
  logic [3:0]         w_cap_digit;
  logic [1:0]         w_slot;
  logic               w_anode_ok;
  logic               w_dwell_hit;
  logic               w_capture;
  logic               w_error;
  logic [3:0]         w_mask_next;
  logic [3:0]         r_mask;
  logic [3:0][3:0]    r_digits;
  logic [3:0]         r_snap_mask;
  logic [3:0][3:0]    r_snap_digits;
  logic [15:0]        r_number;
  logic               r_valid;
  logic               w_enter_convert;
  logic               w_frame_done;
  cap_state_t         r_state;
  cap_state_t         w_state_next;

  assign w_sample = {anode_in, segment_in};
  assign w_anode  = r_sample[10:7];

  // Dwell counter: restarts on any input change, saturates so the hit value occurs once
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_sample <= '0;
      r_count  <= '0;
    end else begin
      r_sample <= w_sample;
      if (w_sample != r_sample) begin
        r_count <= '0;
      end else if (r_count != c_cnt_max) begin
        r_count <= r_count + c_cnt_w'(1);
      end
    end
  end

  seg7_decode u_decode (
    .segments (r_sample[6:0]),
    .digit    (w_digit),
    .legal    (w_legal)
  );

  always_comb begin
    w_slot     = 2'd0;
    w_anode_ok = 1'b0;
    case (w_anode)
      c_an_d3: begin w_slot = 2'd3; w_anode_ok = 1'b1; end
      c_an_d2: begin w_slot = 2'd2; w_anode_ok = 1'b1; end
      c_an_d1: begin w_slot = 2'd1; w_anode_ok = 1'b1; end
      c_an_d0: begin w_slot = 2'd0; w_anode_ok = 1'b1; end
      default: ;
    endcase
  end

  assign w_dwell_hit = (r_count == c_cnt_hit);
  assign w_cap_digit = w_legal ? w_digit : 4'd0;

`ifdef SEG_CAPTURE_ERR_EN
  logic w_blank;
  logic r_pattern_error;

  assign w_blank   = (w_anode == c_an_blank);
  assign w_capture = w_dwell_hit && w_anode_ok && w_legal;
  assign w_error   = w_dwell_hit && !w_blank && !(w_anode_ok && w_legal);

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_pattern_error <= 1'b0;
    end else begin
      r_pattern_error <= w_error;
    end
  end

  assign pattern_error = r_pattern_error;
`else
  assign w_capture = w_dwell_hit && w_anode_ok;
  assign w_error   = 1'b0;
`endif

  // A capture landing on the CONVERT entry cycle seeds the next frame
  always_comb begin
    w_mask_next = w_enter_convert ? 4'h0 : r_mask;
    if (w_error) begin
      w_mask_next = 4'h0;
    end
    if (w_capture) begin
      w_mask_next[w_slot] = 1'b1;
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_mask   <= 4'h0;
      r_digits <= '0;
    end else begin
      r_mask <= w_mask_next;
      if (w_capture) begin
        r_digits[w_slot] <= w_cap_digit;
      end
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: if (r_mask == 4'hF) w_state_next = CONVERT;
      CONVERT: w_state_next = COLLECT;
      default: w_state_next = COLLECT;
    endcase
  end

  always_comb begin
    w_enter_convert = 1'b0;
    w_frame_done    = 1'b0;
    case (r_state)
      COLLECT: w_enter_convert = (r_mask == 4'hF);
      CONVERT: w_frame_done    = (r_snap_mask == 4'hF);
      default: ;
    endcase
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_snap_mask   <= 4'h0;
      r_snap_digits <= '0;
      r_number      <= 16'd0;
      r_valid       <= 1'b0;
    end else begin
      if (w_enter_convert) begin
        r_snap_mask   <= r_mask;
        r_snap_digits <= r_digits;
      end
      r_valid <= w_frame_done;
      if (w_frame_done) begin
        r_number <= {2'b00, frame_value(r_snap_digits)};
      end
    end
  end

  assign captured_number = r_number;
  assign number_valid    = r_valid;

endmodule

`default_nettype wire
